// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-stage load/store unit; one req/ack data-bus access at a
//            time with store lane formatting and load sign/zero extension.
//            Optional misaligned-access trapping: LSU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int DATAW = 32,
  parameter int ADDRW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [DATAW-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_data,
  output logic             rsp_fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [DATAW-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [DATAW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [ADDRW-1:0] r_mem_addr;
  logic [3:0]       r_wstrb;
  logic [DATAW-1:0] r_wdata;
  logic [DATAW-1:0] r_rsp_data;
  logic             r_fault;

  logic             w_accept;
  logic             w_fault;
  logic             w_is_half;
  logic             w_is_word;
  logic [3:0]       w_wstrb;
  logic [DATAW-1:0] w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [DATAW-1:0] w_load_data;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_is_half = (req_funct3[1:0] == 2'b01);
  assign w_is_word = req_funct3[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_fault = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
`else
  assign w_fault = 1'b0;
`endif

  // Store lane formatting; loads drive no strobes.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = req_wdata;
    if (req_we) begin
      if (w_is_word) begin
        w_wstrb = 4'b1111;
      end else if (w_is_half) begin
        w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end else begin
        w_wstrb = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
    end
  end

  // Load extraction; funct3[2] selects zero extension.
  always_comb begin
    case (r_off)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (r_funct3[1]) begin
      w_load_data = mem_rdata;
    end else if (r_funct3[0]) begin
      w_load_data = {{16{~r_funct3[2] & w_half[15]}}, w_half};
    end else begin
      w_load_data = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_fault ? S_DONE : S_BUS;
      S_BUS:   if (mem_ack) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_mem_addr <= '0;
      r_wstrb    <= 4'd0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_off    <= req_addr[1:0];
        r_fault  <= w_fault;
        // A trapped access leaves the bus fields untouched.
        if (w_fault) begin
          r_rsp_data <= '0;
        end else begin
          r_mem_addr <= {req_addr[ADDRW-1:2], 2'b00};
          r_wstrb    <= w_wstrb;
          r_wdata    <= w_wdata;
        end
      end
      if ((r_state == S_BUS) && mem_ack) begin
        r_rsp_data <= r_we ? '0 : w_load_data;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_req   = (r_state == S_BUS);
  assign mem_we    = r_we && (r_state == S_BUS);
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_wstrb;
  assign mem_wdata = r_wdata;
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_fault && (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed scoreboard bench for load_store_unit with a bus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] rdata;
    int          delay;
    logic        fault;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int   vectors;
  int   miscompares;
  int   cyc;
  int   n_accepted;
  int   bus_cnt;
  logic stale_ack;
  txn_t cur;
  txn_t pend_q[$];
  txn_t rsp_q[$];
  int   rsp_cyc_q[$];
  int   acc_q[$];

  load_store_unit #(.DATAW(32), .ADDRW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_fault  (rsp_fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Bus responder and response scoreboard, sampled mid-cycle.
  always begin
    txn_t t;
    int   ec;
    @(negedge clk);
    #2;
    cyc++;
    if (rst_n) begin
      if (rsp_valid) begin
        check("rsp_ready_low", req_ready, 1'b0);
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          t  = rsp_q.pop_front();
          ec = rsp_cyc_q.pop_front();
          check("rsp_data", rsp_data, t.data);
          check("rsp_fault", rsp_fault, t.fault);
          check("rsp_cycle", cyc, ec);
        end
      end
      if (mem_req) begin
        check("bus_on_fault", cur.fault, 1'b0);
        check("bus_ready_low", req_ready, 1'b0);
        check("mem_addr", mem_addr, cur.addr);
        check("mem_wstrb", mem_wstrb, cur.wstrb);
        check("mem_we", mem_we, cur.we);
        if (cur.chk_wdata) check("mem_wdata", mem_wdata, cur.wdata);
        if (bus_cnt == cur.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
        end else begin
          mem_ack = 1'b0;
        end
        bus_cnt++;
      end else begin
        mem_ack = stale_ack;
      end
      if (req_valid && req_ready) begin
        if (pend_q.size() == 0) begin
          check("unexpected_accept", req_valid, 1'b0);
        end else begin
          cur     = pend_q.pop_front();
          bus_cnt = 0;
          acc_q.push_back(cyc);
          rsp_q.push_back(cur);
          rsp_cyc_q.push_back(cur.fault ? cyc + 1 : cyc + 2 + cur.delay);
          n_accepted++;
        end
      end
    end else begin
      mem_ack = stale_ack;
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input int delay,
                       input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic chk_wd,
                       input logic [31:0] exp_data, input logic exp_fault, input logic hold);
    txn_t t;
    int   target;
    t.we = we; t.addr = exp_addr; t.wstrb = exp_strb; t.wdata = exp_wdata;
    t.chk_wdata = chk_wd; t.rdata = rdata; t.delay = delay; t.fault = exp_fault;
    t.data = exp_data;
    pend_q.push_back(t);
    target     = n_accepted + 1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    for (int i = 0; i < 64 && n_accepted < target; i++) @(negedge clk);
    if (n_accepted < target) begin
      expire("accept_timeout");
      pend_q.delete();
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100 && (rsp_q.size() != 0 || pend_q.size() != 0); i++) @(negedge clk);
    if (rsp_q.size() != 0 || pend_q.size() != 0) begin
      expire("drain_timeout");
      rsp_q.delete(); rsp_cyc_q.delete(); pend_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a0;
    vectors = 0; miscompares = 0; cyc = 0; n_accepted = 0; bus_cnt = 0;
    stale_ack = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    cur = '{we: 1'b0, addr: 32'h0, wstrb: 4'h0, wdata: 32'h0, chk_wdata: 1'b0,
            rdata: 32'h0, delay: 0, fault: 1'b0, data: 32'h0};
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wstrb", mem_wstrb, 4'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_fault", rsp_fault, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // LW with a slow ack
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 32'h100, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    drain();
    // Sub-word loads with sign/zero extension
    issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 1, 32'h100, 4'h0, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0);
    drain();
    issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h00000080, 1'b0, 1'b0);
    drain();
    issue(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 2, 32'h100, 4'h0, 32'h0, 1'b0, 32'hFFFF80FF, 1'b0, 1'b0);
    drain();
    issue(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF7F01, 0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h000080FF, 1'b0, 1'b0);
    drain();
    issue(1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF7F01, 0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h0000007F, 1'b0, 1'b0);
    drain();
    // Stores
    issue(1'b1, 3'b000, 32'h201, 32'h123456A5, 32'hFFFFFFFF, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0, 1'b0);
    drain();
    issue(1'b1, 3'b001, 32'h202, 32'hABCD1234, 32'hFFFFFFFF, 0, 32'h200, 4'b1100, 32'h12341234, 1'b1, 32'h0, 1'b0, 1'b0);
    drain();
    issue(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 32'h204, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 1'b0);
    drain();

    // Back-to-back with immediate ack
    a0 = acc_q.size();
    issue(1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, 0, 32'h400, 4'h0, 32'h0, 1'b0, 32'h11111111, 1'b0, 1'b1);
    issue(1'b0, 3'b010, 32'h404, 32'h0, 32'h22222222, 0, 32'h404, 4'h0, 32'h0, 1'b0, 32'h22222222, 1'b0, 1'b0);
    drain();
    if (acc_q.size() >= a0 + 2) check("b2b_spacing", acc_q[a0+1] - acc_q[a0], 3);
    else expire("b2b_accepts");

    // Reset in the middle of a bus access, then a stale ack
    issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h33333333, 20, 32'h300, 4'h0, 32'h0, 1'b0, 32'h33333333, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_q.delete(); rsp_cyc_q.delete();
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    stale_ack = 1'b1;
    @(negedge clk);
    stale_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stale_ack_rsp_valid", rsp_valid, 1'b0);
      check("stale_ack_mem_req", mem_req, 1'b0);
      check("stale_ack_ready", req_ready, 1'b1);
    end

    // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    drain();
    issue(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    drain();
`else
    issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 1, 32'h100, 4'h0, 32'h0, 1'b0, 32'h11223344, 1'b0, 1'b0);
    drain();
    issue(1'b0, 3'b001, 32'h101, 32'h0, 32'h11228765, 0, 32'h100, 4'h0, 32'h0, 1'b0, 32'hFFFF8765, 1'b0, 1'b0);
    drain();
`endif
    // Aligned access still works after the misaligned ones
    issue(1'b0, 3'b101, 32'h502, 32'h0, 32'hBEEF0000, 0, 32'h500, 4'h0, 32'h0, 1'b0, 32'h0000BEEF, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit: accepts one load or store per handshake from the execute stage, runs a request/acknowledge transaction on the word-wide data-memory bus, and returns aligned, sign/zero-extended load data to the writeback stage's memory input. It produces the value that writeback selects for `WB_MEM` (`wb_sel = 2'd0`), and formats store data and byte strobes for memory. One access is in flight at a time; `req_ready` low stalls the pipeline.

## Interface
- `DATAW`, 32: data width (only 32 supported).
- `ADDRW`, 32: byte-address width.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  unit can accept; handshake = `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDRW  byte address (ALU result).
- `req_wdata`  in  DATAW  store data (rs2).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  DATAW  formatted load data to writeback; 0 for stores and faults.
- `rsp_fault`  out  1  misaligned access, qualified by `rsp_valid`.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  ADDRW  word-aligned address; bits [1:0] always 0.
- `mem_wstrb`  out  4  byte-lane write enables.
- `mem_wdata`  out  DATAW  lane-replicated store data.
- `mem_ack`  in  1  bus completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATAW  read word.

## Operation
- FSM states: IDLE, BUS, DONE.
  - IDLE: `req_ready = 1`. On handshake, latch `we`, `funct3`, `addr[1:0]`, bus address, and formatted data/strobes; go to BUS. If the access faults (see Configuration), go to DONE instead.
  - BUS: `mem_req = 1`. `mem_we`, `mem_addr`, `mem_wstrb`, and `mem_wdata` stay stable until `mem_ack`. On `mem_ack`, register the formatted `mem_rdata` and go to DONE.
  - DONE: `rsp_valid = 1` for one cycle, then go to IDLE.
- `req_ready = 0` in BUS and DONE.
- Size is decoded from `funct3[1:0]`: 00 byte, 01 half, 1x word. `funct3[2]` = 1 selects zero-extension on loads and is ignored on stores.
- Store strobes and data:
  - Byte: `wstrb = 4'b0001 << addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - Half: `wstrb = 4'b0011 << (2*addr[1])`, `wdata = {2{rs2[15:0]}}`.
  - Word: `wstrb = 4'b1111`.
- Loads: `mem_wstrb = 0`. Byte is selected by `addr[1:0]`, half by `addr[1]`, then sign- or zero-extended to 32 bits.
- `mem_ack` is ignored outside BUS, including a stale ack after reset.
- `rsp_data` holds its value between pulses; it is only meaningful when `rsp_valid` is high.

## Timing
- Reset values: state IDLE, `req_ready = 1`; `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`, `rsp_valid`, `rsp_data`, and `rsp_fault` all 0.
- Handshake at edge N: `mem_req` is high from cycle N+1. With `mem_ack` sampled at edge M (M ≥ N+1), `rsp_valid` is high in cycle M+1.
- Minimum latency is 2 cycles (ack in the first BUS cycle). Throughput is 1 access per 3 cycles at best.
- Next accept is earliest at the edge after DONE; there is no overlap of DONE and a new handshake.
- A faulting access goes from handshake at N to `rsp_valid` in cycle N+1, with no bus activity.
- Reset during BUS or DONE: at the next edge all outputs return to their reset values and any pending ack is dropped.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Half accesses with `addr[0] = 1`, and word accesses with `addr[1:0] != 0`, never assert `mem_req`.
  - They complete via DONE with `rsp_fault = 1` and `rsp_data = 0`.
- Undefined:
  - `rsp_fault` is tied to 0.
  - Offending low address bits are ignored: half uses `addr[1]`, word uses the aligned word.
  - Every access goes to the bus.

## Test plan
- LW to 0x100, ack 3 cycles after `mem_req`, `mem_rdata = 0xDEADBEEF` -> `mem_addr = 0x100`, `mem_wstrb = 0`, `rsp_data = 0xDEADBEEF` one cycle after ack, `req_ready` low throughout.
- LB / LBU / LH / LHU at 0x103 and 0x102 with `mem_rdata = 0x80FF7F01`:
  - LB @0x103 -> 0xFFFFFF80; LBU @0x103 -> 0x00000080.
  - LH @0x102 -> 0xFFFF80FF; LHU @0x102 -> 0x000080FF.
- SB 0xA5 to 0x201 -> `mem_addr = 0x200`, `wstrb = 0010`, `wdata = 0xA5A5A5A5`. SH 0x1234 to 0x202 -> `wstrb = 1100`, `wdata = 0x12341234`. Both get `rsp_data = 0`.
- `mem_ack` in the first BUS cycle, back-to-back requests held valid -> `rsp_valid` 2 cycles after accept; accepts spaced exactly 3 cycles apart.
- `rst_n` low during BUS, then `mem_ack` pulsed after release -> `mem_req` 0 the next cycle, no `rsp_valid`, FSM in IDLE.
- LW to 0x102:
  - With `LSU_MISALIGN_TRAP_EN` -> no `mem_req`; `rsp_valid` and `rsp_fault` high one cycle after accept.
  - Without it -> bus read of 0x100, `rsp_fault = 0`.
